// File: rtl/status_uart_pkg.sv
// Shared types and constants for the status UART transmitter.
package status_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int   FRAME_BITS_NOPAR = 10;  // start + 8 data + stop
  localparam int   FRAME_BITS_PAR   = 11;  // start + 8 data + parity + stop
  localparam logic LINE_IDLE        = 1'b1;

endpackage

// File: rtl/status_uart_fifo.sv
// Byte FIFO for the status UART: single clock, registered read on pop, occupancy count.
module status_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [7:0]    rd_data_reg;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
        rd_data_reg <= mem[rd_ptr_reg];
      end
      if (do_wr && !do_rd) begin
        count_reg <= count_reg + CW'(1);
      end else if (do_rd && !do_wr) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  assign rd_data = rd_data_reg;
  assign count   = count_reg;

endmodule

// File: rtl/status_uart_tx.sv
// FIFO-buffered UART transmitter, 8N1 by default; defining STATUS_UART_PARITY_EN adds an
// even-parity bit (8E1).
module status_uart_tx
  import status_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [1:0]  rst_sync_reg;
  logic        rst_n;
  logic        fifo_pop;
  logic [7:0]  fifo_rd_data;
  logic        fifo_full;
  logic        fifo_empty;

  uart_state_t state_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]  bit_reg;
  logic [6:0]  shift_reg;
  logic        tx_reg;
  logic        baud_done;
`ifdef STATUS_UART_PARITY_EN
  logic        parity_reg;
`endif

  // Reset asserts asynchronously but releases two edges later, so no flop sees a runt edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_reg[1];

  assign ready_o  = !fifo_full;
  assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;

  status_uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (rst_n),
    .wr_en   (valid_i && ready_o),
    .wr_data (data_i),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_done = (baud_reg == BW'(CLKS_PER_BIT - 1));

  // The popped byte sits in the FIFO read register for the whole START bit.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      tx_reg     <= LINE_IDLE;
`ifdef STATUS_UART_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          baud_reg <= '0;
          bit_reg  <= '0;
          tx_reg   <= LINE_IDLE;
          if (!fifo_empty) begin
            state_reg <= ST_START;
            tx_reg    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_reg   <= '0;
            state_reg  <= ST_DATA;
            tx_reg     <= fifo_rd_data[0];
            shift_reg  <= fifo_rd_data[7:1];
`ifdef STATUS_UART_PARITY_EN
            parity_reg <= ^fifo_rd_data;
`endif
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (bit_reg == 3'd7) begin
`ifdef STATUS_UART_PARITY_EN
              state_reg <= ST_PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= ST_STOP;
              tx_reg    <= LINE_IDLE;
`endif
            end else begin
              bit_reg   <= bit_reg + 3'd1;
              tx_reg    <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[6:1]};
            end
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
`ifdef STATUS_UART_PARITY_EN
        ST_PARITY: begin
          if (baud_done) begin
            baud_reg  <= '0;
            state_reg <= ST_STOP;
            tx_reg    <= LINE_IDLE;
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (baud_done) begin
            baud_reg  <= '0;
            state_reg <= ST_IDLE;
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= LINE_IDLE;
        end
      endcase
    end
  end

  assign tx_o   = tx_reg;
  assign busy_o = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_status_uart_tx.sv
// Directed bench for status_uart_tx with a serial-line receiver model (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_status_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef STATUS_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk;
  logic       wb_rst_n_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       tx_o;
  logic       busy_o;
  logic [2:0] fifo_count_o;

  int n_checks;
  int n_errors;
  int framing_errs;
  logic [7:0] rx_q[$];

  status_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (wb_rst_n_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    data_i  = d;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int cyc;
    cyc = 0;
    while (busy_o !== 1'b0 && cyc < limit) begin
      tick();
      cyc++;
    end
    chk("idle_within_bound", 32'(busy_o), 32'd0);
  endtask

  task automatic chk_rx(input logic [7:0] exp);
    chk("rx_available", 32'(rx_q.size() != 0), 32'd1);
    if (rx_q.size() != 0) begin
      chk("rx_byte", 32'(rx_q.pop_front()), 32'(exp));
    end
  endtask

  // Bit index 0 = start, 1..8 = data LSB first, 9 = parity (11-bit frame) or stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && NBITS == 11) return par;
    return 1'b1;
  endfunction

  task automatic check_frame(input logic [7:0] d, input logic par);
    push(d);
    chk("push_count", 32'(fifo_count_o), 32'd1);
    chk("push_busy", 32'(busy_o), 32'd1);
    for (int k = 0; k < NBITS * CPB; k++) begin
      tick();
      chk($sformatf("frame_%02h_c%0d", d, k), 32'(tx_o), 32'(frame_bit(d, par, k / CPB)));
    end
    chk("busy_at_stop_end", 32'(busy_o), 32'd1);
    tick();
    chk("busy_after_stop", 32'(busy_o), 32'd0);
    chk("tx_after_stop", 32'(tx_o), 32'd1);
    chk_rx(d);
  endtask

  // Line receiver: centre-samples each bit after detecting a start bit.
  initial begin
    logic [7:0] rb;
    framing_errs = 0;
    forever begin
      tick();
      if (wb_rst_n_i === 1'b1 && tx_o === 1'b0) begin
        repeat (CPB / 2) tick();
        if (tx_o !== 1'b0) framing_errs++;
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) tick();
          rb[b] = tx_o;
        end
        if (NBITS == 11) begin
          repeat (CPB) tick();
          if (tx_o !== ^rb) framing_errs++;
        end
        repeat (CPB) tick();
        if (tx_o !== 1'b1) framing_errs++;
        rx_q.push_back(rb);
      end
    end
  end

  initial begin
    logic [7:0] vals [6];
    int bad;
    int w;
    n_checks   = 0;
    n_errors   = 0;
    wb_rst_n_i = 1'b0;
    valid_i    = 1'b0;
    data_i     = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_count", 32'(fifo_count_o), 32'd0);
    wb_rst_n_i = 1'b1;
    repeat (4) tick();
    chk("idle_tx", 32'(tx_o), 32'd1);

    // Single frames (parity bits hand-computed: 0x55->0, 0x07->1, 0x03->0)
    check_frame(8'h55, 1'b0);
    check_frame(8'h07, 1'b1);
    check_frame(8'h03, 1'b0);

    // Full FIFO: 5 accepted, 6th dropped
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    vals[3] = 8'h44; vals[4] = 8'h5A; vals[5] = 8'h66;
    for (int i = 0; i < 6; i++) begin
      data_i  = vals[i];
      valid_i = 1'b1;
      tick();
      if (i == 1) chk("full_count_after_2", 32'(fifo_count_o), 32'd1);
      if (i == 4) begin
        chk("full_count", 32'(fifo_count_o), 32'd4);
        chk("full_ready", 32'(ready_o), 32'd0);
      end
      if (i == 5) chk("full_drop_count", 32'(fifo_count_o), 32'd4);
    end
    valid_i = 1'b0;
    wait_idle(400);
    for (int i = 0; i < 5; i++) chk_rx(vals[i]);
    chk("full_no_extra", 32'(rx_q.size()), 32'd0);

    // Simultaneous push and pop with count=1
    push(8'hC3);
    push(8'h3C);
    chk("simul_count", 32'(fifo_count_o), 32'd1);
    repeat (NBITS * CPB) tick();
    chk("simul_gap_tx", 32'(tx_o), 32'd1);
    chk("simul_gap_busy", 32'(busy_o), 32'd1);
    tick();
    chk("simul_second_start", 32'(tx_o), 32'd0);
    chk("simul_count_after", 32'(fifo_count_o), 32'd0);
    wait_idle(100);
    chk_rx(8'hC3);
    chk_rx(8'h3C);

    // Reset mid-frame during data bit 3 of 0xA3 (bit 3 = 0)
    push(8'hA3);
    push(8'hC4);
    chk("rstmid_count", 32'(fifo_count_o), 32'd1);
    repeat (17) tick();
    chk("rstmid_bit3", 32'(tx_o), 32'd0);
    wb_rst_n_i = 1'b0;
    #1;
    chk("rstmid_tx", 32'(tx_o), 32'd1);
    chk("rstmid_count0", 32'(fifo_count_o), 32'd0);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_ready", 32'(ready_o), 32'd1);
    repeat (3) tick();
    wb_rst_n_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    chk("rstmid_line_idle", 32'(bad), 32'd0);
    rx_q.delete();
    framing_errs = 0;

    // Pointer wrap: 12 bytes through a 4-deep FIFO
    for (int i = 0; i < 12; i++) begin
      w = 0;
      while (ready_o !== 1'b1 && w < 200) begin
        tick();
        w++;
      end
      chk("wrap_ready", 32'(ready_o), 32'd1);
      push(8'(i));
    end
    wait_idle(1000);
    chk("wrap_rx_count", 32'(rx_q.size()), 32'd12);
    for (int i = 0; i < 12; i++) chk_rx(8'(i));
    chk("framing_errors", 32'(framing_errs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/status_uart_tx.md
STATUS_UART_TX -- requirements
Module: status_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 347, is the clock cycles per UART bit (40 MHz / 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 8, is the byte FIFO depth; it SHALL be a power of two and at least 2.
REQ-003 Port wb_clk_i, input, 1 bit, is the single clock; all logic is on its rising edge.
REQ-004 Port wb_rst_n_i, input, 1 bit, is an asynchronous active-low reset.
REQ-005 Port data_i, input, 8 bits, is the byte to transmit.
REQ-006 Port valid_i, input, 1 bit, means data_i is valid.
REQ-007 Port ready_o, output, 1 bit, means the FIFO can accept a byte.
REQ-008 Port tx_o, output, 1 bit, is the UART serial line, idle high.
REQ-009 Port busy_o, output, 1 bit, is high while a frame is shifting or the FIFO is non-empty.
REQ-010 Port fifo_count_o, output, clog2(FIFO_DEPTH)+1 bits, is the current FIFO occupancy.

Function
REQ-011 A byte SHALL be accepted on a rising edge where valid_i and ready_o are both 1.
REQ-012 ready_o SHALL equal (fifo_count_o != FIFO_DEPTH).
REQ-013 When the FIFO is full, valid_i SHALL be ignored with no overwrite and no count change.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
- IDLE -> START on any edge where the FIFO is non-empty; this pops the FIFO.
- START -> DATA, DATA -> (PARITY or STOP), STOP -> IDLE, each after CLKS_PER_BIT cycles.
REQ-015 A byte accepted at edge N into an empty FIFO while IDLE SHALL drive tx_o low (start bit) from edge N+1.
REQ-016 Data SHALL be sent LSB first, 8 bits, each held exactly CLKS_PER_BIT cycles, using a bit counter of 0..7.
REQ-017 The stop bit SHALL be one bit time of tx_o=1, followed by IDLE.
REQ-018 Back-to-back frames with no idle gap: STOP SHALL go to IDLE for exactly one cycle, then START.
REQ-019 A push and a pop on the same edge SHALL leave fifo_count_o unchanged and keep data ordered.
REQ-020 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 tx_o SHALL be driven from a flop (glitch-free); the baud counter SHALL count 0..CLKS_PER_BIT-1 and reload on each bit boundary.

Reset
REQ-022 While wb_rst_n_i=0, regardless of the clock:
- tx_o=1, ready_o=1, busy_o=0, fifo_count_o=0
- state=IDLE; pointers and counters cleared
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with tx_o returning high asynchronously and the FIFO contents discarded.
REQ-024 Reset deassertion SHALL be synchronised internally through a two-flop release so the first active edge is clean.

Configuration
REQ-025 Macro STATUS_UART_PARITY_EN, when defined, SHALL enable the PARITY state: one bit time of even parity (XOR of the 8 data bits) between DATA and STOP, giving an 11-bit frame.
REQ-026 With STATUS_UART_PARITY_EN undefined, DATA SHALL go directly to STOP (10-bit frame, 8N1) and no parity logic is synthesised.

Structure
REQ-027 Package status_uart_pkg SHALL hold the FSM state enum typedef, the frame bit-count constants (with and without parity) and the idle line level constant.
REQ-028 The FIFO SHALL be sub-module status_uart_fifo (synchronous, single clock, count output); the FSM, baud counter and shifter stay in status_uart_tx.

Verification
REQ-029 The bench SHALL run with CLKS_PER_BIT=4 and FIFO_DEPTH=4, and SHALL cover at least these scenarios:
- Single byte: push 0x55 at edge N -> tx_o low from N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles; 40 cycles total; busy_o falls after STOP.
- Full: 5 pushes while line is busy -> the first pops into the shifter, the next 4 fill the FIFO, ready_o=0; a 6th push is dropped; the line carries exactly 5 frames in order.
- Simultaneous: push on the same edge as the IDLE->START pop with count=1 -> fifo_count_o stays 1; the 2 bytes go out in push order with a 1-cycle gap.
- Reset mid-frame: assert wb_rst_n_i during data bit 3 of 0xA3 -> tx_o=1 immediately; after release the line stays idle with no residual frame.
- Parity (macro defined): push 0x07 -> parity bit 1, frame 44 cycles.
- Parity (macro defined): push 0x03 -> parity bit 0.
- Pointer wrap: 12 sequential bytes 0x00..0x0B -> received in order via tbuart-style checker with no loss.
